led_ctrl: RTL

- Parametrised LED/indicator controller; generalises the single fixed-rate blinker and the direct key-to-LED copy into NB_LED independent channels.
- Per-channel mode: off, follow level, common blink, event pulse-stretch.
- Includes a key synchroniser/debouncer that produces a clean level and a press pulse.
- Sits in Top between the system/user logic and the LED[] pins, clocked by sys_clk (100 MHz).

---
 rtl/led_ctrl_if.sv | 32 +++
 rtl/led_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/led_ctrl_if.sv
// led_ctrl_if: bundles the LED controller's user-side signals.
//   mode      2*NB_LED  per-channel mode, channel i at [2i+1:2i]
//   lvl       NB_LED    follow-mode level sources
//   evt       NB_LED    stretch-mode event strobes
//   key_n     1         raw push-button, active-low, asynchronous
//   key_db    1         debounced key, 1 = pressed
//   key_press 1         one-cycle pulse on accepted press
//   tick      1         one-cycle prescaler strobe
//   led       NB_LED    LED drive, 1 = lit
// master = user logic side, slave = led_ctrl side.
interface led_ctrl_if #(
   parameter int unsigned NB_LED = 8
);
   logic [2*NB_LED-1:0] mode;
   logic [NB_LED-1:0]   lvl;
   logic [NB_LED-1:0]   evt;
   logic                key_n;
   logic                key_db;
   logic                key_press;
   logic                tick;
   logic [NB_LED-1:0]   led;

   modport master (
      output mode, lvl, evt, key_n,
      input  key_db, key_press, tick, led
   );

   modport slave (
      input  mode, lvl, evt, key_n,
      output key_db, key_press, tick, led
   );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: NB_LED-channel LED controller with shared prescaler, common blink phase,
// per-channel event pulse-stretchers and a key synchroniser/debouncer.
//   sys_clk  system clock
//   sys_rst  synchronous reset, active-high
//   bus      led_ctrl_if slave: mode/lvl/evt/key_n in; key_db/key_press/tick/led out
// All outputs are registered.
module led_ctrl #(
   parameter int unsigned NB_LED        = 8,
   parameter int unsigned TICK_DIV      = 100000,
   parameter int unsigned BLINK_TICKS   = 500,
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned DEB_TICKS     = 20
) (
   input logic        sys_clk,
   input logic        sys_rst,
   led_ctrl_if.slave  bus
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int unsigned SW = $clog2(STRETCH_TICKS + 1);
   localparam int unsigned DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

   localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BcLast  = BW'(BLINK_TICKS - 1);
   localparam logic [SW-1:0] ScLoad  = SW'(STRETCH_TICKS);
   localparam logic [DW-1:0] DcLast  = DW'(DEB_TICKS - 1);

   logic [PW-1:0]     pre_q, pre_d;
   logic              tick_stb;
   logic              tick_q;
   logic [BW-1:0]     bc_q, bc_d;
   logic              phase_q, phase_d;
   logic [SW-1:0]     sc_q [NB_LED];
   logic [SW-1:0]     sc_d [NB_LED];
   logic [NB_LED-1:0] led_q, led_d;
   logic              sync1_q, ks_q;
   logic              st_q, st_d;
   logic [DW-1:0]     dc_q, dc_d;
   logic              key_db_q, key_press_q;

   // Internal tick event; counters advance on the same edge that raises the tick output.
   assign tick_stb = (pre_q == PreLast);

   always_comb begin
      pre_d   = tick_stb ? '0 : pre_q + 1'b1;
      bc_d    = bc_q;
      phase_d = phase_q;
      if (tick_stb) begin
         if (bc_q == BcLast) begin
            bc_d    = '0;
            phase_d = ~phase_q;
         end else begin
            bc_d = bc_q + 1'b1;
         end
      end
   end

   // Stretch counters run in every mode; a load beats a same-cycle decrement.
   always_comb begin
      for (int i = 0; i < NB_LED; i++) begin
         sc_d[i] = sc_q[i];
         if (bus.evt[i]) begin
            sc_d[i] = ScLoad;
         end else if (tick_stb && (sc_q[i] != '0)) begin
            sc_d[i] = sc_q[i] - 1'b1;
         end
      end
   end

   // LEDs follow the next-state of phase/stretch so they change on the edge the counters do.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < NB_LED; i++) begin
         case (bus.mode[2*i +: 2])
            2'b00:   led_d[i] = 1'b0;
            2'b01:   led_d[i] = bus.lvl[i];
            2'b10:   led_d[i] = phase_d;
            default: led_d[i] = (sc_d[i] != '0);
         endcase
      end
   end

   // Debounce: DEB_TICKS consecutive ticks with ks != st are needed to accept a new level.
   always_comb begin
      st_d = st_q;
      dc_d = dc_q;
      if (tick_stb) begin
         if (ks_q == st_q) begin
            dc_d = '0;
         end else if (dc_q == DcLast) begin
            st_d = ks_q;
            dc_d = '0;
         end else begin
            dc_d = dc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pre_q       <= '0;
         tick_q      <= 1'b0;
         bc_q        <= '0;
         phase_q     <= 1'b0;
         led_q       <= '0;
         sync1_q     <= 1'b1;
         ks_q        <= 1'b1;
         st_q        <= 1'b1;
         dc_q        <= '0;
         key_db_q    <= 1'b0;
         key_press_q <= 1'b0;
         for (int i = 0; i < NB_LED; i++) begin
            sc_q[i] <= '0;
         end
      end else begin
         pre_q       <= pre_d;
         tick_q      <= tick_stb;
         bc_q        <= bc_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         sync1_q     <= bus.key_n;
         ks_q        <= sync1_q;
         st_q        <= st_d;
         dc_q        <= dc_d;
         key_db_q    <= ~st_d;
         key_press_q <= st_q & ~st_d;
         for (int i = 0; i < NB_LED; i++) begin
            sc_q[i] <= sc_d[i];
         end
      end
   end

   assign bus.led       = led_q;
   assign bus.tick      = tick_q;
   assign bus.key_db    = key_db_q;
   assign bus.key_press = key_press_q;

endmodule
